// File: rtl/ps2_kbd_ctrl_if.sv
// ps2_kbd_ctrl_if
// Groups the handshake between the PS/2 receiver FIFO and the keyboard
// sequencer.
//   fifo_data      head byte of the FIFO, valid while fifo_ready=1
//   fifo_ready     FIFO non-empty
//   fifo_overflow  overflow flag from the receiver
//   fifo_nextdata  pop strobe; the FIFO advances on the clk edge where it is 1
// Modports: master = FIFO side, slave = sequencer side.
interface ps2_kbd_ctrl_if;
  logic [7:0] fifo_data;
  logic       fifo_ready;
  logic       fifo_overflow;
  logic       fifo_nextdata;

  modport master (
    output fifo_data,
    output fifo_ready,
    output fifo_overflow,
    input  fifo_nextdata
  );

  modport slave (
    input  fifo_data,
    input  fifo_ready,
    input  fifo_overflow,
    output fifo_nextdata
  );
endinterface

// File: rtl/ps2_kbd_ctrl.sv
// ps2_kbd_ctrl
// Pops scan-code bytes from the PS/2 receiver FIFO, decodes the
// make / break (F0) / extended (E0) protocol, tracks the single held key,
// counts distinct presses and drives the seven-segment display information.
// Ports:
//   clk, rst      system clock; asynchronous active-low reset
//   fifo          ps2_kbd_ctrl_if.slave (fifo_data, fifo_ready,
//                 fifo_overflow in; fifo_nextdata out)
//   clr           synchronous clear of key_cnt, ovf_err and decode state
//   key_code      scan code of the held or last key
//   key_ext       held or last key carried an E0 prefix
//   key_valid     a key is currently held
//   key_cnt       distinct key presses, modulo 2^CNT_W
//   seg_en        display enable (same as key_valid)
//   ovf_err       sticky FIFO-overflow indication
// Build option: define KBD_EXT_EN to decode the E0 prefix. Without it E0
// bytes are popped and discarded and key_ext stays 0.
module ps2_kbd_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  ps2_kbd_ctrl_if.slave    fifo,
  input  logic             clr,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic             key_valid,
  output logic [CNT_W-1:0] key_cnt,
  output logic             seg_en,
  output logic             ovf_err
);

  localparam logic       F_IDLE  = 1'b0;
  localparam logic       F_DEC   = 1'b1;
  localparam logic [1:0] P_MAKE  = 2'd0;
  localparam logic [1:0] P_EXT   = 2'd1;
  localparam logic [1:0] P_BREAK = 2'd2;

  localparam logic [7:0] BYTE_E0 = 8'hE0;
  localparam logic [7:0] BYTE_F0 = 8'hF0;

  logic       f_state;
  logic [1:0] p_state;
  logic [1:0] p_next;
  logic [7:0] byte_r;
  logic       make_ev;
  logic       break_ev;
  logic       ev_ext;
  logic       key_match;

  // Pop only from F_IDLE; clr and reset both suppress the strobe so the
  // FIFO never advances while the decoder is being cleared.
  assign fifo.fifo_nextdata = rst && !clr && (f_state == F_IDLE) && fifo.fifo_ready;

  assign seg_en = key_valid;

  // The same match rule identifies a typematic repeat on make and a
  // release of the held key on break.
  assign key_match = key_valid && (byte_r == key_code) && (ev_ext == key_ext);

`ifdef KBD_EXT_EN
  logic ext_pend;
  logic ext_next;

  assign ev_ext = ext_pend;

  // Protocol decode of byte_r; only consumed while the fetch FSM is in F_DEC.
  always_comb begin
    make_ev  = 1'b0;
    break_ev = 1'b0;
    p_next   = p_state;
    ext_next = ext_pend;
    case (p_state)
      P_MAKE: begin
        if (byte_r == BYTE_E0) begin
          p_next   = P_EXT;
          ext_next = 1'b1;
        end else if (byte_r == BYTE_F0) begin
          p_next = P_BREAK;
        end else begin
          make_ev = 1'b1;
        end
      end
      P_EXT: begin
        if (byte_r == BYTE_F0) begin
          p_next = P_BREAK;
        end else if (byte_r != BYTE_E0) begin
          make_ev = 1'b1;
        end
      end
      P_BREAK: break_ev = 1'b1;
      default: p_next = P_MAKE;
    endcase
    if (make_ev || break_ev) begin
      p_next   = P_MAKE;
      ext_next = 1'b0;
    end
  end

  // ext_pend follows the protocol FSM and is dropped by clr and reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ext_pend <= 1'b0;
    end else if (clr) begin
      ext_pend <= 1'b0;
    end else if (f_state == F_DEC) begin
      ext_pend <= ext_next;
    end
  end
`else
  assign ev_ext = 1'b0;

  // Protocol decode without extended keys: E0 is swallowed with no state
  // change, so E0 F0 xx behaves exactly like F0 xx.
  always_comb begin
    make_ev  = 1'b0;
    break_ev = 1'b0;
    p_next   = p_state;
    if (byte_r != BYTE_E0) begin
      case (p_state)
        P_MAKE: begin
          if (byte_r == BYTE_F0) begin
            p_next = P_BREAK;
          end else begin
            make_ev = 1'b1;
          end
        end
        P_BREAK: begin
          break_ev = 1'b1;
          p_next   = P_MAKE;
        end
        default: p_next = P_MAKE;
      endcase
    end
  end
`endif

  // Fetch FSM, protocol state and all registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      f_state   <= F_IDLE;
      p_state   <= P_MAKE;
      byte_r    <= 8'h00;
      key_code  <= 8'h00;
      key_ext   <= 1'b0;
      key_valid <= 1'b0;
      key_cnt   <= '0;
      ovf_err   <= 1'b0;
    end else if (clr) begin
      f_state   <= F_IDLE;
      p_state   <= P_MAKE;
      key_valid <= 1'b0;
      key_cnt   <= '0;
      ovf_err   <= 1'b0;
    end else begin
      if (fifo.fifo_overflow) begin
        ovf_err <= 1'b1;
      end
      case (f_state)
        F_IDLE: begin
          if (fifo.fifo_ready) begin
            byte_r  <= fifo.fifo_data;
            f_state <= F_DEC;
          end
        end
        default: begin
          f_state <= F_IDLE;
          p_state <= p_next;
          if (make_ev && !key_match) begin
            key_code  <= byte_r;
            key_ext   <= ev_ext;
            key_valid <= 1'b1;
            key_cnt   <= key_cnt + CNT_W'(1);
          end
          if (break_ev && key_match) begin
            key_valid <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// tb_ps2_kbd_ctrl
// Directed bench for ps2_kbd_ctrl. Bytes go into a FIFO model together with
// the hand-computed display state expected after that byte; a monitor pops
// the expectation two edges after the DUT pops the byte and compares.
// Honours KBD_EXT_EN for the expected values of E0 sequences.
module tb_ps2_kbd_ctrl;

`ifdef KBD_EXT_EN
  localparam bit EXT = 1'b1;
`else
  localparam bit EXT = 1'b0;
`endif

  typedef struct {
    logic [7:0] code;
    logic       ext;
    logic       valid;
    logic [7:0] cnt;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_valid;
  logic [7:0] key_cnt;
  logic       seg_en;
  logic       ovf_err;

  ps2_kbd_ctrl_if fifo ();

  ps2_kbd_ctrl #(.CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .fifo      (fifo),
    .clr       (clr),
    .key_code  (key_code),
    .key_ext   (key_ext),
    .key_valid (key_valid),
    .key_cnt   (key_cnt),
    .seg_en    (seg_en),
    .ovf_err   (ovf_err)
  );

  always #5 clk = ~clk;

  logic [7:0] byte_q[$];
  exp_t       exp_q[$];
  int         due_q[$];
  int         pop_cyc_q[$];
  int         n_checks = 0;
  int         n_pass = 0;
  int         cyc = 0;
  int         pop_cnt = 0;
  int         consec_err = 0;
  int         rst_pop_err = 0;
  int         byte_idx = 0;
  bit         pop_now = 1'b0;
  bit         prev_nd = 1'b0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic [7:0] code, input logic ext,
                           input logic valid, input logic [7:0] cnt);
    exp_t e;
    e.code = code; e.ext = ext; e.valid = valid; e.cnt = cnt;
    byte_q.push_back(b);
    exp_q.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while ((byte_q.size() != 0 || exp_q.size() != 0 || due_q.size() != 0) && n < 4000) begin
      @(posedge clk);
      n++;
    end
    #1;
    check_output("drain_done", (n < 4000) ? 32'd1 : 32'd0, 32'd1);
  endtask

  // Pop decision is taken at the falling edge; inputs only change after rising edges.
  initial begin
    forever begin
      @(negedge clk);
      pop_now = fifo.fifo_nextdata;
      if (fifo.fifo_nextdata && prev_nd) consec_err++;
      if (fifo.fifo_nextdata && !rst) rst_pop_err++;
      prev_nd = fifo.fifo_nextdata;
    end
  end

  // FIFO model: drives head byte and ready, advances on popped edges.
  initial begin
    fifo.fifo_data     = 8'h00;
    fifo.fifo_ready    = 1'b0;
    fifo.fifo_overflow = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (pop_now && byte_q.size() > 0) void'(byte_q.pop_front());
      fifo.fifo_ready = (byte_q.size() > 0);
      fifo.fifo_data  = (byte_q.size() > 0) ? byte_q[0] : 8'h00;
    end
  end

  // Monitor: outputs for a byte popped at edge N are compared after edge N+2.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        void'(due_q.pop_front());
        if (exp_q.size() == 0) begin
          check_output("unexpected_pop", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check_output($sformatf("b%0d_code", byte_idx), key_code, e.code);
          check_output($sformatf("b%0d_ext", byte_idx), key_ext, e.ext);
          check_output($sformatf("b%0d_valid", byte_idx), key_valid, e.valid);
          check_output($sformatf("b%0d_seg_en", byte_idx), seg_en, e.valid);
          check_output($sformatf("b%0d_cnt", byte_idx), key_cnt, e.cnt);
          byte_idx++;
        end
      end
      if (pop_now) begin
        due_q.push_back(cyc + 2);
        pop_cyc_q.push_back(cyc);
        pop_cnt++;
      end
    end
  end

  initial begin
    int c;
    int base_pops;
    logic [7:0] k;

    // Reset values
    #3;
    check_output("rst_code", key_code, 8'h00);
    check_output("rst_ext", key_ext, 1'b0);
    check_output("rst_valid", key_valid, 1'b0);
    check_output("rst_cnt", key_cnt, 8'h00);
    check_output("rst_seg_en", seg_en, 1'b0);
    check_output("rst_ovf", ovf_err, 1'b0);
    check_output("rst_nextdata", fifo.fifo_nextdata, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    tick();

    // Make then break
    send_byte(8'h1C, 8'h1C, 1'b0, 1'b1, 8'd1);
    send_byte(8'hF0, 8'h1C, 1'b0, 1'b1, 8'd1);
    send_byte(8'h1C, 8'h1C, 1'b0, 1'b0, 8'd1);
    drain();

    // Typematic repeats do not count
    send_byte(8'h1C, 8'h1C, 1'b0, 1'b1, 8'd2);
    send_byte(8'h1C, 8'h1C, 1'b0, 1'b1, 8'd2);
    send_byte(8'h1C, 8'h1C, 1'b0, 1'b1, 8'd2);
    send_byte(8'hF0, 8'h1C, 1'b0, 1'b1, 8'd2);
    send_byte(8'h1C, 8'h1C, 1'b0, 1'b0, 8'd2);
    drain();

    // Extended key press / release
    send_byte(8'hE0, 8'h1C, 1'b0, 1'b0, 8'd2);
    send_byte(8'h75, 8'h75, EXT, 1'b1, 8'd3);
    send_byte(8'hE0, 8'h75, EXT, 1'b1, 8'd3);
    send_byte(8'hF0, 8'h75, EXT, 1'b1, 8'd3);
    send_byte(8'h75, 8'h75, EXT, 1'b0, 8'd3);
    // Plain break of an extended key leaves it held (only with E0 decoding)
    send_byte(8'hE0, 8'h75, EXT, 1'b0, 8'd3);
    send_byte(8'h75, 8'h75, EXT, 1'b1, 8'd4);
    send_byte(8'hF0, 8'h75, EXT, 1'b1, 8'd4);
    send_byte(8'h75, 8'h75, EXT, EXT, 8'd4);
    send_byte(8'hE0, 8'h75, EXT, EXT, 8'd4);
    send_byte(8'hF0, 8'h75, EXT, EXT, 8'd4);
    send_byte(8'h75, 8'h75, EXT, 1'b0, 8'd4);
    drain();

    // Replacement of the held key; stale break ignored
    send_byte(8'h1C, 8'h1C, 1'b0, 1'b1, 8'd5);
    send_byte(8'h32, 8'h32, 1'b0, 1'b1, 8'd6);
    send_byte(8'hF0, 8'h32, 1'b0, 1'b1, 8'd6);
    send_byte(8'h1C, 8'h32, 1'b0, 1'b1, 8'd6);
    send_byte(8'hF0, 8'h32, 1'b0, 1'b1, 8'd6);
    send_byte(8'h32, 8'h32, 1'b0, 1'b0, 8'd6);
    // Same code with different prefix is a new key when E0 is decoded
    send_byte(8'hE0, 8'h32, 1'b0, 1'b0, 8'd6);
    send_byte(8'h75, 8'h75, EXT, 1'b1, 8'd7);
    send_byte(8'h75, 8'h75, 1'b0, 1'b1, EXT ? 8'd8 : 8'd7);
    send_byte(8'hF0, 8'h75, 1'b0, 1'b1, EXT ? 8'd8 : 8'd7);
    send_byte(8'h75, 8'h75, 1'b0, 1'b0, EXT ? 8'd8 : 8'd7);
    drain();

    // Back-to-back: six bytes waiting, pops every other cycle
    c = EXT ? 8 : 7;
    pop_cyc_q.delete();
    base_pops = pop_cnt;
    send_byte(8'h11, 8'h11, 1'b0, 1'b1, 8'(c + 1));
    send_byte(8'h22, 8'h22, 1'b0, 1'b1, 8'(c + 2));
    send_byte(8'h33, 8'h33, 1'b0, 1'b1, 8'(c + 3));
    send_byte(8'h44, 8'h44, 1'b0, 1'b1, 8'(c + 4));
    send_byte(8'h55, 8'h55, 1'b0, 1'b1, 8'(c + 5));
    send_byte(8'h66, 8'h66, 1'b0, 1'b1, 8'(c + 6));
    drain();
    check_output("b2b_pops", pop_cnt - base_pops, 6);
    check_output("b2b_pop_log", pop_cyc_q.size(), 6);
    for (int i = 1; i < pop_cyc_q.size(); i++)
      check_output($sformatf("b2b_gap%0d", i), pop_cyc_q[i] - pop_cyc_q[i-1], 2);

    // Counter wrap: clear, then 256 distinct presses
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check_output("clr_cnt", key_cnt, 8'h00);
    check_output("clr_valid", key_valid, 1'b0);
    for (int i = 0; i < 256; i++) begin
      k = (i % 2 == 0) ? 8'h1C : 8'h32;
      send_byte(k, k, 1'b0, 1'b1, 8'(i + 1));
    end
    drain();
    check_output("wrap_cnt", key_cnt, 8'h00);
    send_byte(8'hF0, 8'h32, 1'b0, 1'b1, 8'h00);
    send_byte(8'h32, 8'h32, 1'b0, 1'b0, 8'h00);
    drain();

    // Sticky overflow, then clr beating a simultaneous overflow
    fifo.fifo_overflow = 1'b1;
    tick();
    fifo.fifo_overflow = 1'b0;
    check_output("ovf_set", ovf_err, 1'b1);
    tick();
    tick();
    tick();
    check_output("ovf_sticky", ovf_err, 1'b1);
    send_byte(8'h4D, 8'h4D, 1'b0, 1'b1, 8'h01);
    drain();
    clr = 1'b1;
    fifo.fifo_overflow = 1'b1;
    tick();
    clr = 1'b0;
    fifo.fifo_overflow = 1'b0;
    check_output("clr_ovf", ovf_err, 1'b0);
    check_output("clr_ovf_cnt", key_cnt, 8'h00);
    check_output("clr_ovf_valid", key_valid, 1'b0);

    // No pop while clr is held
    clr = 1'b1;
    base_pops = pop_cnt;
    send_byte(8'h1C, 8'h1C, 1'b0, 1'b1, 8'h01);
    tick();
    tick();
    @(negedge clk);
    check_output("clr_nextdata", fifo.fifo_nextdata, 1'b0);
    tick();
    check_output("clr_no_pop", pop_cnt - base_pops, 0);
    clr = 1'b0;
    drain();

    // Reset between F0 and the code byte discards the pending break
    send_byte(8'hF0, 8'h1C, 1'b0, 1'b1, 8'h01);
    drain();
    rst = 1'b0;
    #1;
    check_output("arst_code", key_code, 8'h00);
    check_output("arst_ext", key_ext, 1'b0);
    check_output("arst_valid", key_valid, 1'b0);
    check_output("arst_cnt", key_cnt, 8'h00);
    check_output("arst_seg_en", seg_en, 1'b0);
    check_output("arst_ovf", ovf_err, 1'b0);
    send_byte(8'h1C, 8'h1C, 1'b0, 1'b1, 8'h01);
    tick();
    tick();
    @(negedge clk);
    check_output("arst_nextdata", fifo.fifo_nextdata, 1'b0);
    tick();
    rst = 1'b1;
    drain();

    check_output("consecutive_pops", consec_err, 0);
    check_output("pop_in_reset", rst_pop_err, 0);

    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
